// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Stall / flush / freeze controller for a classic 5-stage in-order pipeline.
//   Resolves three hazard sources with fixed priority:
//     data-memory freeze  >  taken branch  >  load-use interlock
//   A multi-cycle data-memory access parks the controller in MEM_WAIT. A
//   watchdog moves it to HALT if the access exceeds TIMEOUT wait cycles, and
//   only reset leaves HALT.
//
// Ports
//   clk, reset        pipeline clock; asynchronous active-high reset
//   id_rs, id_rt      ID-stage source registers
//   id_uses_rt        ID instruction actually reads rt
//   ex_memread, ex_rd EX-stage load flag and destination register
//   branch_taken      branch/jump resolved taken in EX
//   mem_req, mem_ready MEM-stage access request / completion handshake
//   cnt_clear         synchronous clear of stall_cycles
//   pc_en .. memwb_en pipeline register enables (combinational)
//   ifid_flush, idex_flush  bubble insertion into IF/ID and ID/EX
//   memwb_bubble      forces RegWrite/MemtoReg low into MEM/WB
//   mem_timeout       sticky watchdog error flag
//   state             RUN=0, MEM_WAIT=1, HALT=2
//   stall_cycles      saturating count of cycles with pc_en low
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        cnt_clear,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        memwb_bubble,
   output logic        mem_timeout,
   output logic [1:0]  state,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   // The wait counter is 8 bits wide, so the limit is compared in that width.
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   // Control vector bit order:
   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble}
   localparam logic [7:0] CTRL_RUN    = 8'b1101_0110;
   localparam logic [7:0] CTRL_BRANCH = 8'b1111_1110;
   localparam logic [7:0] CTRL_LDUSE  = 8'b0001_1110;
   // MEM/WB keeps moving during a freeze, but it receives a bubble.
   localparam logic [7:0] CTRL_FREEZE = 8'b0000_0011;
   localparam logic [7:0] CTRL_HALT   = 8'b0000_0001;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [7:0]  wait_cnt_r;
   logic [7:0]  wait_cnt_nxt_s;
   logic        mem_timeout_r;
   logic        mem_timeout_nxt_s;
   logic [15:0] stall_cycles_r;
   logic [7:0]  run_ctrl_s;
   logic [7:0]  ctrl_s;
   logic        load_use_s;

   // A load whose destination feeds the next instruction; r0 never creates a dependency.
   assign load_use_s = ex_memread && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   // Outputs while running with no memory freeze: branch beats load-use.
   always_comb begin
      run_ctrl_s = CTRL_RUN;
      if (branch_taken) begin
         run_ctrl_s = CTRL_BRANCH;
      end else if (load_use_s) begin
         run_ctrl_s = CTRL_LDUSE;
      end else begin
         run_ctrl_s = CTRL_RUN;
      end
   end

   // Next-state, wait counter, watchdog and control outputs.
   always_comb begin
      state_nxt_s       = state_r;
      wait_cnt_nxt_s    = wait_cnt_r;
      mem_timeout_nxt_s = mem_timeout_r;
      ctrl_s            = run_ctrl_s;
      case (state_r)
         RUN: begin
            if (mem_req && !mem_ready) begin
               ctrl_s         = CTRL_FREEZE;
               state_nxt_s    = MEM_WAIT;
               wait_cnt_nxt_s = 8'd1;
            end else begin
               ctrl_s = run_ctrl_s;
            end
         end
         MEM_WAIT: begin
            if (!mem_ready) begin
               ctrl_s = CTRL_FREEZE;
               if (wait_cnt_r == TIMEOUT_C) begin
                  state_nxt_s       = HALT;
                  mem_timeout_nxt_s = 1'b1;
               end else begin
                  wait_cnt_nxt_s = wait_cnt_r + 8'd1;
               end
            end else begin
               // The access completes this cycle, so the hazards are evaluated as in RUN.
               ctrl_s         = run_ctrl_s;
               state_nxt_s    = RUN;
               wait_cnt_nxt_s = 8'd0;
            end
         end
         HALT: begin
            ctrl_s = CTRL_HALT;
         end
         default: begin
            // An unreachable encoding is treated as a fault and the pipeline is parked.
            ctrl_s      = CTRL_HALT;
            state_nxt_s = HALT;
         end
      endcase
   end

   // State, wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= RUN;
         wait_cnt_r    <= 8'd0;
         mem_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         wait_cnt_r    <= wait_cnt_nxt_s;
         mem_timeout_r <= mem_timeout_nxt_s;
      end
   end

   // Saturating count of cycles with the PC held; a clear wins over an increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_r <= 16'd0;
      end else if (cnt_clear) begin
         stall_cycles_r <= 16'd0;
      end else if (!ctrl_s[7] && (stall_cycles_r != 16'hFFFF)) begin
         stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble} = ctrl_s;
   assign mem_timeout  = mem_timeout_r;
   assign state        = state_r;
   assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scenarios for pipeline_ctrl, using TIMEOUT=4. Expected values
//   are queued when the stimulus is applied and compared once the outputs
//   have settled. The inputs change on the falling edge. Outputs are sampled
//   1 time unit later, so state and stall_cycles reflect the preceding
//   rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam logic [7:0] C_RUN  = 8'b1101_0110;
   localparam logic [7:0] C_BR   = 8'b1111_1110;
   localparam logic [7:0] C_LU   = 8'b0001_1110;
   localparam logic [7:0] C_FRZ  = 8'b0000_0011;
   localparam logic [7:0] C_HALT = 8'b0000_0001;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rt, ex_memread, branch_taken, mem_req, mem_ready, cnt_clear;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble;
   logic        mem_timeout;
   logic [1:0]  state;
   logic [15:0] stall_cycles;

   typedef struct {
      string       tag;
      logic [7:0]  ctrl;
      logic [1:0]  st;
      logic [15:0] stall;
      logic        tmo;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pipeline_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clear(cnt_clear),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .memwb_bubble(memwb_bubble),
      .mem_timeout(mem_timeout), .state(state), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic memread, input logic [4:0] rd, input logic br,
                         input logic req, input logic rdy, input logic clr);
      id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; ex_memread = memread; ex_rd = rd;
      branch_taken = br; mem_req = req; mem_ready = rdy; cnt_clear = clr;
   endtask

   task automatic push_exp(input string tag, input logic [7:0] c, input logic [1:0] st,
                           input logic [15:0] stall, input logic tmo);
      exp_t e;
      e.tag = tag; e.ctrl = c; e.st = st; e.stall = stall; e.tmo = tmo;
      sb_q.push_back(e);
   endtask

   task automatic compare_pop();
      exp_t e;
      logic [7:0] obs;
      obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble};
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq({e.tag, "_ctrl"},  32'(obs),          32'(e.ctrl));
         check_eq({e.tag, "_state"}, 32'(state),        32'(e.st));
         check_eq({e.tag, "_stall"}, 32'(stall_cycles), 32'(e.stall));
         check_eq({e.tag, "_tmo"},   32'(mem_timeout),  32'(e.tmo));
      end
   endtask

   // One cycle: queue the expectation, sample after settling, then advance to the next falling edge.
   task automatic cyc(input string tag, input logic [7:0] c, input logic [1:0] st,
                      input logic [15:0] stall, input logic tmo);
      push_exp(tag, c, st, stall, tmo);
      #1;
      compare_pop();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      push_exp("reset", C_RUN, 2'd0, 16'd0, 1'b0);
      #3;
      compare_pop();
      @(negedge clk);
      reset = 1'b0;

      cyc("idle", C_RUN, 2'd0, 16'd0, 1'b0);

      // Load-use on rs, then via rt only when id_uses_rt is set.
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("lu_rs", C_LU, 2'd0, 16'd0, 1'b0);
      set_in(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("lu_rt", C_LU, 2'd0, 16'd1, 1'b0);
      set_in(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("rt_unused", C_RUN, 2'd0, 16'd2, 1'b0);
      set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("rd_zero", C_RUN, 2'd0, 16'd2, 1'b0);
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("br_over_lu", C_BR, 2'd0, 16'd2, 1'b0);

      // Three freeze cycles (a branch during a freeze is ignored), then completion with a branch.
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("frz1", C_FRZ, 2'd0, 16'd2, 1'b0);
      branch_taken = 1'b1;
      cyc("frz2_br", C_FRZ, 2'd1, 16'd3, 1'b0);
      branch_taken = 1'b0;
      cyc("frz3", C_FRZ, 2'd1, 16'd4, 1'b0);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc("mw_done_br", C_BR, 2'd1, 16'd5, 1'b0);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("back_run_clr", C_RUN, 2'd0, 16'd5, 1'b0);
      cnt_clear = 1'b0;
      cyc("cleared", C_RUN, 2'd0, 16'd0, 1'b0);

      // Reset while in MEM_WAIT acts without a clock edge; outputs then follow RUN with the inputs.
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("mw_enter", C_FRZ, 2'd0, 16'd0, 1'b0);
      push_exp("mw_held", C_FRZ, 2'd1, 16'd1, 1'b0);
      #1;
      compare_pop();
      reset = 1'b1;
      push_exp("async_rst", C_FRZ, 2'd0, 16'd0, 1'b0);
      #1;
      compare_pop();
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      cyc("post_rst", C_RUN, 2'd0, 16'd0, 1'b0);

      // Watchdog with TIMEOUT=4: RUN plus four MEM_WAIT cycles, then HALT.
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("wd0", C_FRZ, 2'd0, 16'd0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc($sformatf("wd%0d", i), C_FRZ, 2'd1, 16'(i), 1'b0);
      end
      cyc("halt", C_HALT, 2'd2, 16'd5, 1'b1);
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("halt_sticky", C_HALT, 2'd2, 16'd6, 1'b1);

      // HALT keeps pc_en low, so stall_cycles runs up to saturation.
      repeat (65540) @(negedge clk);
      cnt_clear = 1'b1;
      cyc("sat", C_HALT, 2'd2, 16'hFFFF, 1'b1);
      cnt_clear = 1'b0;
      cyc("sat_clr", C_HALT, 2'd2, 16'd0, 1'b1);
      cyc("sat_inc", C_HALT, 2'd2, 16'd1, 1'b1);

      // Only reset leaves HALT.
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      push_exp("halt_rst", C_RUN, 2'd0, 16'd0, 1'b0);
      #1;
      compare_pop();

      if (sb_q.size() != 0) begin
         check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
